// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: one radix-2 step per cycle,
// fixed XLEN-cycle latency for every operation, valid/ready on both sides.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state, state_nxt;

    // Operation context captured at accept
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  a_q;
    logic             neg_prod_q;
    logic             neg_rem_q;
    logic             div_zero_q;

    // Iteration registers: product high/low for multiply, remainder/quotient for divide
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  mcand_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             last_step;
    logic             load_result;

    logic             a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]  mag_a, mag_b;

    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic             div_ge;
    logic [XLEN-1:0]  div_diff;
    logic [XLEN-1:0]  step_hi, step_lo;

    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   result_nxt;

    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign accept      = in_valid & in_ready & ~flush;
    assign last_step   = (state == S_BUSY) && (cnt_q == CNT_W'(XLEN - 1));
    assign load_result = last_step & ~flush;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept)    state_nxt = S_BUSY;
                S_BUSY:  if (last_step) state_nxt = S_DONE;
                S_DONE:  if (out_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Operand signedness and magnitudes for the incoming request
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (in_op[2]) begin
            a_signed = ~in_op[0];
            b_signed = ~in_op[0];
        end else begin
            a_signed = (in_op[1:0] == 2'b01) || (in_op[1:0] == 2'b10);
            b_signed = (in_op[1:0] == 2'b01);
        end
        a_neg = a_signed & in_a[XLEN-1];
        b_neg = b_signed & in_b[XLEN-1];
        mag_a = a_neg ? -in_a : in_a;
        mag_b = b_neg ? -in_b : in_b;
    end

    // One radix-2 step: shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN + 1){1'b0}});
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        div_diff  = div_shift[XLEN-1:0] - mcand_q;
        step_hi   = '0;
        step_lo   = '0;
        if (op_q[2]) begin
            step_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection from the final step
    always_comb begin
        prod_raw = {step_hi, step_lo};
        prod_fix = neg_prod_q ? -prod_raw : prod_raw;
        quo      = neg_prod_q ? -step_lo : step_lo;
        rem      = neg_rem_q ? -step_hi : step_hi;
        if (div_zero_q) begin
            quo = '1;
            rem = a_q;
        end
        result_nxt = '0;
        if (op_q[2]) begin
            result_nxt = op_q[1] ? rem : quo;
        end else if (op_q[1:0] == 2'b00) begin
            result_nxt = prod_fix[XLEN-1:0];
        end else begin
            result_nxt = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Datapath registers: load on accept, iterate while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            tag_q      <= '0;
            a_q        <= '0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            mcand_q    <= '0;
            cnt_q      <= '0;
        end else if (accept) begin
            op_q       <= in_op;
            tag_q      <= in_tag;
            a_q        <= in_a;
            neg_prod_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= in_op[2] && (in_b == '0);
            hi_q       <= '0;
            lo_q       <= mag_a;
            mcand_q    <= mag_b;
            cnt_q      <= '0;
        end else if (state == S_BUSY) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Result and tag registers, held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_tag    <= '0;
        end else if (load_result) begin
            out_result <= result_nxt;
            out_tag    <= tag_q;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32: directed vectors, monitor pops on handshake.
module tb_muldiv_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every delivered result is matched against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%0h tag %0d expected no result",
                         out_result, out_tag);
            end else begin
                mon_e = sb.pop_front();
                check("result", 64'(out_result), 64'(mon_e.res));
                check("tag", 64'(out_tag), 64'(mon_e.tag));
            end
        end
    end

    // Present a request; returns once it is accepted (we are then in BUSY cycle 1)
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp_res,
                         input bit push, output int waited);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
        end else if (push) begin
            sb.push_back(exp_t'{res: exp_res, tag: tag});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        in_tag   = TAG_W'($urandom);
    endtask

    // Count cycles from BUSY cycle 1 until out_valid rises
    task automatic wait_done(output int k);
        k = 1;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: out_valid stayed 0 expected 1");
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                       input logic [XLEN-1:0] exp_res);
        int w;
        int k;
        issue(op, a, b, tag, exp_res, 1'b1, w);
        wait_done(k);
        check($sformatf("%s_latency", name), 64'(k), 64'(XLEN + 1));
        @(posedge clk); #1;
    endtask

    task automatic watch_quiet(input string name, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        int w;
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Arithmetic vectors
        run("mul",       OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB);
        run("mulh_min",  OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000);
        run("mulhu_max", OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE);
        run("mulhsu",    OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF);
        run("mul_shift", OP_MUL,    32'h1234_5678,  32'h0000_0010, 5'd7,  32'h2345_6780);
        run("mulh_neg",  OP_MULH,   32'd3,          32'hFFFF_FFFE, 5'd8,  32'hFFFF_FFFF);
        run("mulh_pos",  OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd9,  32'h0000_0000);
        run("div_neg",   OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD);
        run("rem_neg",   OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF);
        run("div_negb",  OP_DIV,    32'd7,          32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD);
        run("rem_negb",  OP_REM,    32'd7,          32'hFFFF_FFFE, 5'd13, 32'h0000_0001);
        run("divu_z",    OP_DIVU,   32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF);
        run("remu_z",    OP_REMU,   32'd5,          32'd0,         5'd15, 32'h0000_0005);
        run("div_z",     OP_DIV,    32'd5,          32'd0,         5'd16, 32'hFFFF_FFFF);
        run("rem_z",     OP_REM,    32'hFFFF_FFFB,  32'd0,         5'd17, 32'hFFFF_FFFB);
        run("div_ovf",   OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'h8000_0000);
        run("rem_ovf",   OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h0000_0000);

        // Backpressure in DONE, then back-to-back request
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, 1'b1, w);
        wait_done(k);
        check("bp_latency", 64'(k), 64'(XLEN + 1));
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_result_hold", 64'(out_result), 64'd14);
            check("bp_tag_hold", 64'(out_tag), 64'd20);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue(OP_REMU, 32'd100, 32'd7, 5'd21, 32'd2, 1'b1, w);
        check("b2b_accept_wait", 64'(w), 64'd1);
        wait_done(k);
        check("b2b_latency", 64'(k), 64'(XLEN + 1));
        @(posedge clk); #1;

        // Flush in IDLE blocks that cycle's accept
        in_valid = 1'b1;
        in_op    = OP_MUL;
        in_a     = 32'd9;
        in_b     = 32'd9;
        in_tag   = 5'd22;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_in_ready", 64'(in_ready), 64'd1);

        // Flush on BUSY cycle 10 kills the operation
        issue(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd23, 32'd0, 1'b0, w);
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        watch_quiet("flush_no_result", 40);
        run("after_flush", OP_DIVU, 32'd1000, 32'd10, 5'd24, 32'd100);

        // Asynchronous reset in the middle of BUSY
        issue(OP_DIV, 32'd77, 32'd7, 5'd25, 32'd0, 1'b0, w);
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_result", 64'(out_result), 64'd0);
        check("arst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        watch_quiet("arst_no_result", 40);
        run("after_reset", OP_MUL, 32'd11, 32'd13, 5'd26, 32'd143);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog against a hung handshake
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
